// File: rtl/game_pkg.sv
// Shared types and constants for the multi-enemy tank game controller.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    localparam logic MODE_CLASSIC = 1'b0;
    localparam logic MODE_TIMED   = 1'b1;

    localparam int DISP_W = 16;

endpackage

// File: rtl/game_logic_multi_score_adder_sat.sv
// N-input saturating adder; each channel is zero-extended and the sum clamps at all-ones.
module score_adder_sat #(
    parameter int N_ENEMY = 4,
    parameter int SCORE_W = 5,
    parameter int TOTAL_W = 8
) (
    input  logic [N_ENEMY*SCORE_W-1:0] scores,
    output logic [TOTAL_W-1:0]         sum
);

    // Wide enough accumulator that the full sum of up to 8 channels never wraps.
    localparam int ACC_W = TOTAL_W + SCORE_W + 4;
    localparam logic [ACC_W-1:0] SAT_C = {{(ACC_W-TOTAL_W){1'b0}}, {TOTAL_W{1'b1}}};

    logic [ACC_W-1:0] acc_s;

    // Accumulate all channels, then clamp to the output range.
    always_comb begin
        acc_s = {ACC_W{1'b0}};
        for (int i = 0; i < N_ENEMY; i++) begin
            acc_s = acc_s + ACC_W'(scores[i*SCORE_W +: SCORE_W]);
        end
        if (acc_s > SAT_C) begin
            sum = {TOTAL_W{1'b1}};
        end else begin
            sum = acc_s[TOTAL_W-1:0];
        end
    end

endmodule

// File: rtl/game_logic_multi.sv
// Game controller: score summing, HP with hit/heal, optional countdown, final and high score.
module game_logic_multi
    import game_pkg::*;
#(
    parameter int N_ENEMY   = 4,
    parameter int SCORE_W   = 5,
    parameter int TOTAL_W   = 8,
    parameter int HP_W      = 5,
    parameter int HP_INIT   = 8,
    parameter int HP_MAX    = 16,
    parameter int TIME_INIT = 60
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable_game,
    input  logic                       mode,
    input  logic                       clear_score,
    input  logic                       mytank_state,
    input  logic                       heal,
    input  logic                       sec_tick,
    input  logic [N_ENEMY*SCORE_W-1:0] scores,
    output logic [HP_W-1:0]            hp_value,
    output logic [7:0]                 time_left,
    output logic [DISP_W-1:0]          seg_value,
    output logic [DISP_W-1:0]          led_value,
    output logic                       gameover,
    output logic [TOTAL_W-1:0]         final_score,
    output logic [TOTAL_W-1:0]         high_score
);

    localparam logic [HP_W-1:0] HP_INIT_C   = HP_W'(HP_INIT);
    localparam logic [HP_W-1:0] HP_MAX_C    = HP_W'(HP_MAX);
    localparam logic [7:0]      TIME_INIT_C = 8'(TIME_INIT);

    state_t               state_r, state_next_s;
    logic                 mode_r, prev_tank_r, gameover_r, hit_s, end_s;
    logic [HP_W-1:0]      hp_r, hp_next_s;
    logic [7:0]           time_r, time_next_s;
    logic [TOTAL_W-1:0]   sum_s, score_r, final_r, high_r;

    score_adder_sat #(
        .N_ENEMY(N_ENEMY),
        .SCORE_W(SCORE_W),
        .TOTAL_W(TOTAL_W)
    ) u_adder (
        .scores(scores),
        .sum   (sum_s)
    );

    // Candidate HP/timer values for a PLAY cycle and the game-ending condition they imply.
    always_comb begin
        hit_s = prev_tank_r & ~mytank_state;
        if (hit_s && !heal) begin
            if (hp_r != {HP_W{1'b0}}) begin
                hp_next_s = hp_r - {{(HP_W-1){1'b0}}, 1'b1};
            end else begin
                hp_next_s = hp_r;
            end
        end else if (heal && !hit_s) begin
            if (hp_r < HP_MAX_C) begin
                hp_next_s = hp_r + {{(HP_W-1){1'b0}}, 1'b1};
            end else begin
                hp_next_s = hp_r;
            end
        end else begin
            hp_next_s = hp_r;
        end
        if (mode_r == MODE_TIMED && sec_tick && time_r != 8'd0) begin
            time_next_s = time_r - 8'd1;
        end else begin
            time_next_s = time_r;
        end
        end_s = (hp_next_s == {HP_W{1'b0}}) || (mode_r == MODE_TIMED && time_next_s == 8'd0);
    end

    // Next-state logic; an abort takes priority over a simultaneous end condition.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable_game) state_next_s = ST_PLAY;
                else             state_next_s = ST_IDLE;
            end
            ST_PLAY: begin
                if (!enable_game) state_next_s = ST_IDLE;
                else if (end_s)   state_next_s = ST_OVER;
                else              state_next_s = ST_PLAY;
            end
            ST_OVER: begin
                if (!enable_game) state_next_s = ST_IDLE;
                else              state_next_s = ST_OVER;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= ST_IDLE;
        else        state_r <= state_next_s;
    end

    // Game datapath: edge detect, HP, timer, live/final/high score, gameover flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_tank_r <= 1'b1;
            mode_r      <= MODE_CLASSIC;
            gameover_r  <= 1'b0;
            hp_r        <= HP_INIT_C;
            time_r      <= TIME_INIT_C;
            score_r     <= {TOTAL_W{1'b0}};
            final_r     <= {TOTAL_W{1'b0}};
            high_r      <= {TOTAL_W{1'b0}};
        end else begin
            prev_tank_r <= mytank_state;
            case (state_r)
                ST_IDLE: begin
                    if (enable_game) begin
                        hp_r    <= HP_INIT_C;
                        time_r  <= TIME_INIT_C;
                        mode_r  <= mode;
                        final_r <= {TOTAL_W{1'b0}};
                        score_r <= {TOTAL_W{1'b0}};
                    end else if (clear_score) begin
                        final_r <= {TOTAL_W{1'b0}};
                    end else begin
                        final_r <= final_r;
                    end
                end
                ST_PLAY: begin
                    score_r <= sum_s;
                    hp_r    <= hp_next_s;
                    time_r  <= time_next_s;
                    if (state_next_s == ST_OVER) begin
                        gameover_r <= 1'b1;
                        final_r    <= score_r;
                        if (score_r > high_r) high_r <= score_r;
                        else                  high_r <= high_r;
                    end else begin
                        gameover_r <= 1'b0;
                    end
                end
                ST_OVER: begin
                    if (!enable_game) gameover_r <= 1'b0;
                    else              gameover_r <= 1'b1;
                end
                default: gameover_r <= 1'b0;
            endcase
        end
    end

    // Display mux and HP thermometer, both decoded from registered state.
    always_comb begin
        seg_value = {DISP_W{1'b0}};
        case (state_r)
            ST_PLAY: seg_value = DISP_W'(score_r);
            ST_OVER: seg_value = DISP_W'(final_r);
            ST_IDLE: begin
                if (clear_score) seg_value = {DISP_W{1'b0}};
                else             seg_value = DISP_W'(final_r);
            end
            default: seg_value = {DISP_W{1'b0}};
        endcase
        for (int i = 0; i < DISP_W; i++) begin
            led_value[i] = (32'(hp_r) > 32'(i));
        end
    end

    assign hp_value    = hp_r;
    assign time_left   = time_r;
    assign gameover    = gameover_r;
    assign final_score = final_r;
    assign high_score  = high_r;

endmodule
